// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: handshaked RV32IM execute unit, 1-cycle base ALU plus iterative mul/div
module alu_mdu_seq #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [SHW-1:0] cnt;
  logic [4:0] op;
  logic neg, accept, is_m, is_div_in, is_div, dz, ovf, special, last, s1, s2, n1, n2, ge;
  logic [XLEN-1:0] hi, lo, d, hi_n, lo_n, fast, mag1, mag2, res_last;
  logic [XLEN:0] mul_sum, div_diff;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [SHW-1:0] sh;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready && !kill;
  assign sh = in2[SHW-1:0];
  assign is_m = alu_op[4:2] == 3'b011 || alu_op[4:2] == 3'b100;
  assign is_div_in = alu_op[4:2] == 3'b100;
  assign is_div = op[4:2] == 3'b100;
  assign dz = in2 == '0;
  assign ovf = in1 == {1'b1, {(XLEN-1){1'b0}}} && &in2 && !alu_op[0];
  assign special = is_div_in && (dz || ovf);
  assign s1 = is_div_in ? !alu_op[0] : (alu_op == 5'd13 || alu_op == 5'd14);
  assign s2 = is_div_in ? !alu_op[0] : alu_op == 5'd13;
  assign n1 = s1 && in1[XLEN-1];
  assign n2 = s2 && in2[XLEN-1];
  assign mag1 = n1 ? -in1 : in1;
  assign mag2 = n2 ? -in2 : in2;
  assign last = cnt == SHW'(XLEN-1);
  // Single-cycle result: base ops, reserved ops and the divide special cases
  always_comb begin
    case (alu_op)
      5'd0:  fast = in1 + in2;
      5'd1:  fast = in1 - in2;
      5'd2:  fast = in1 & in2;
      5'd3:  fast = in1 | in2;
      5'd4:  fast = in1 ^ in2;
      5'd5:  fast = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      5'd6:  fast = in1 << sh;
      5'd7:  fast = {{(XLEN-1){1'b0}}, in1 < in2};
      5'd8:  fast = in1 >> sh;
      5'd9:  fast = $signed(in1) >>> sh;
      5'd10: fast = in1;
      5'd11: fast = in2;
      5'd16, 5'd17: fast = dz ? '1 : in1;
      5'd18, 5'd19: fast = dz ? in1 : '0;
      default: fast = '0;
    endcase
  end
  // One shift-add or restoring shift-subtract step, with sign fix-up for the final step
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    div_diff = {hi, lo[XLEN-1]} - {1'b0, d};
    ge = !div_diff[XLEN];
    hi_n = is_div ? (ge ? div_diff[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]}) : mul_sum[XLEN:1];
    lo_n = is_div ? {lo[XLEN-2:0], ge} : {mul_sum[0], lo[XLEN-1:1]};
    prod = {hi_n, lo_n};
    prod_f = neg ? -prod : prod;
    res_last = is_div ? (op[1] ? (neg ? -hi_n : hi_n) : (neg ? -lo_n : lo_n))
             : (op == 5'd12 ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN]);
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Next state; kill wins over accept and out_ready
  always_comb begin
    state_n = state;
    if (kill) state_n = IDLE;
    else if (state == IDLE) state_n = accept ? ((is_m && !special) ? BUSY : DONE) : IDLE;
    else if (state == BUSY) state_n = last ? DONE : BUSY;
    else state_n = out_ready ? IDLE : DONE;
  end
  // Operand latch, iteration registers and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
      cnt <= '0;
      neg <= 1'b0;
      hi <= '0;
      lo <= '0;
      d <= '0;
      alu_out <= '0;
    end else if (accept) begin
      op <= alu_op;
      cnt <= '0;
      neg <= (is_div_in && alu_op[1]) ? n1 : n1 ^ n2;
      hi <= '0;
      lo <= is_div_in ? mag1 : mag2;
      d <= is_div_in ? mag2 : mag1;
      alu_out <= fast;
    end else if (state == BUSY && !kill) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 1'b1;
      if (last) alu_out <= res_last;
    end
  end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed checks of alu_mdu_seq at XLEN=32 and XLEN=16
module tb_alu_mdu_seq;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n = 0, kill = 0, in_valid = 0, out_ready = 0;
  logic [4:0] alu_op = 0;
  logic [31:0] in1 = 0, in2 = 0;
  logic in_ready, out_valid;
  logic [31:0] alu_out;
  logic v16 = 0, or16 = 0, ir16, ov16;
  logic [4:0] op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, out16;
  int checks = 0, errors = 0;

  alu_mdu_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .kill(kill), .in_valid(in_valid),
    .in_ready(in_ready), .alu_op(alu_op), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out));
  alu_mdu_seq #(.XLEN(16)) dut16 (.clk(clk), .rst_n(rst_n), .kill(1'b0), .in_valid(v16),
    .in_ready(ir16), .alu_op(op16), .in1(a16), .in2(b16), .out_valid(ov16),
    .out_ready(or16), .alu_out(out16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, b,
                     input logic [31:0] exp, input int exp_lat);
    int lat;
    int rdy;
    alu_op = op; in1 = a; in2 = b; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in1 = 32'hDEADBEEF; in2 = 32'h12345678; alu_op = 5'd3;
    lat = 1; rdy = in_ready;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      rdy |= in_ready;
    end
    check({tag, "_res"}, alu_out, exp);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdy"}, rdy, 0);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic run16(input string tag, input logic [4:0] op, input logic [15:0] a, b,
                       input logic [15:0] exp, input int exp_lat);
    int lat;
    op16 = op; a16 = a; b16 = b; v16 = 1;
    @(posedge clk); #1;
    v16 = 0; a16 = 16'hBEEF; b16 = 16'h1234;
    lat = 1;
    while (!ov16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_res"}, out16, exp);
    check({tag, "_lat"}, lat, exp_lat);
    or16 = 1;
    @(posedge clk); #1;
    or16 = 0;
  endtask

  initial begin
    int ok;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", alu_out, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    run("add", 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1);
    run("sub", 5'd1, 32'h0, 32'h1, 32'hFFFFFFFF, 1);
    run("slt", 5'd5, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
    run("sltu", 5'd7, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run("sra", 5'd9, 32'h80000000, 32'h4, 32'hF8000000, 1);
    run("sll", 5'd6, 32'h1, 32'h21, 32'h2, 1);
    run("xor", 5'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    run("cp2", 5'd11, 32'h1, 32'hCAFE0001, 32'hCAFE0001, 1);
    run("rsvd", 5'd25, 32'h5, 32'h6, 32'h0, 1);
    run("mul", 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33);
    run("mulhu", 5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mulh", 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33);
    run("mulhsu", 5'd14, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33);
    run("mul_neg", 5'd12, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mulh_min", 5'd13, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run("mulhsu_min", 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run("div", 5'd16, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
    run("rem", 5'd18, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
    run("divu", 5'd17, 32'd100, 32'd7, 32'd14, 33);
    run("remu", 5'd19, 32'd100, 32'd7, 32'd2, 33);
    run("div_nd", 5'd16, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run("rem_nd", 5'd18, 32'd7, 32'hFFFFFFFE, 32'h1, 33);
    run("divu_big", 5'd17, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 33);
    run("div_z", 5'd16, 32'h1234, 32'h0, 32'hFFFFFFFF, 1);
    run("remu_z", 5'd19, 32'd5, 32'h0, 32'd5, 1);
    run("div_ovf", 5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf", 5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    // backpressure: result held, inputs ignored while DONE
    alu_op = 5'd0; in1 = 1; in2 = 2; in_valid = 1;
    @(posedge clk); #1;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (!(out_valid === 1'b1 && alu_out === 32'd3 && in_ready === 1'b0)) ok = 0;
      in1 = i + 50;
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("hold_stable", ok, 1);
    check("hold_res", alu_out, 3);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    // kill at BUSY step 5
    alu_op = 5'd17; in1 = 100; in2 = 7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) begin @(posedge clk); #1; end
    check("kbusy_busy", in_ready, 0);
    kill = 1;
    @(posedge clk); #1;
    kill = 0;
    check("kbusy_ready", in_ready, 1);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      ok |= out_valid;
      @(posedge clk); #1;
    end
    check("kbusy_noout", ok, 0);
    // kill together with out_ready in DONE
    alu_op = 5'd0; in1 = 4; in2 = 5; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("kdone_valid", out_valid, 1);
    kill = 1; out_ready = 1;
    @(posedge clk); #1;
    kill = 0; out_ready = 0;
    check("kdone_out_valid", out_valid, 0);
    check("kdone_ready", in_ready, 1);
    // kill beats accept in IDLE
    alu_op = 5'd0; in1 = 1; in2 = 1; in_valid = 1; kill = 1;
    @(posedge clk); #1;
    in_valid = 0; kill = 0;
    check("kidle_out_valid", out_valid, 0);
    check("kidle_ready", in_ready, 1);
    // asynchronous reset mid-BUSY
    alu_op = 5'd12; in1 = 3; in2 = 5; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_alu_out", alu_out, 0);
    rst_n = 1;
    #1;
    check("arst_rel_ready", in_ready, 1);
    run("add_after_rst", 5'd0, 32'd2, 32'd3, 32'd5, 1);
    // XLEN=16 instance
    run16("a16", 5'd0, 16'h7FFF, 16'h1, 16'h8000, 1);
    run16("sra16", 5'd9, 16'h8000, 16'h4, 16'hF800, 1);
    run16("mulhu16", 5'd15, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
    run16("mul16", 5'd12, 16'hFFFF, 16'hFFFF, 16'h1, 17);
    run16("div16", 5'd16, 16'hFFF9, 16'h2, 16'hFFFD, 17);
    run16("rem16", 5'd18, 16'hFFF9, 16'h2, 16'hFFFF, 17);
    run16("ovf16", 5'd16, 16'h8000, 16'hFFFF, 16'h8000, 1);
    run16("divz16", 5'd17, 16'h9, 16'h0, 16'hFFFF, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, handshaked execute unit for the RV32IM core. Successor to the combinational integer ALU.
- Keeps the same 12 base operations (encodings 0-11) with 1-cycle registered latency.
- Adds the RV M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), computed iteratively over XLEN cycles.
- Sits between decode/operand-fetch and writeback. Valid/ready on both sides lets the pipeline stall on long operations.

Parameters:
- XLEN, 32: operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN): shift-amount width (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- kill  input  1  synchronous abort of any in-flight/held operation.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  unit can accept (high only in IDLE).
- alu_op  input  5  operation code, see Behaviour.
- in1  input  XLEN  operand 1 (rs1).
- in2  input  XLEN  operand 2 (rs2 or imm).
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer takes result.
- alu_out  output  XLEN  result, held stable while out_valid.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SLTU, 8 SRL, 9 SRA, 10 COPY in1, 11 COPY in2.
  - 12 MUL (low XLEN), 13 MULH (s×s high), 14 MULHSU (s×u high), 15 MULHU (u×u high).
  - 16 DIV, 17 DIVU, 18 REM, 19 REMU.
  - 20-31 result 0.
- Shifts use in2[SHW-1:0]. SLT/SLTU give 1 or 0, zero-extended to XLEN. Add/sub wrap modulo 2^XLEN.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1. Accept on in_valid&&in_ready; operands and op are latched.
  - Base op, reserved op, or M special case -> DONE with result registered, so out_valid rises 1 cycle after the accept edge.
  - Other M op -> BUSY with step counter = 0.
- BUSY:
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle; counter increments.
  - After XLEN steps -> DONE. Latency is XLEN+1 cycles from the accept edge (33 at XLEN=32).
  - Signed ops operate on magnitudes; the sign fix-up is applied on the final step.
- DONE:
  - out_valid=1 and alu_out held.
  - out_ready -> IDLE. No new accept in the same cycle; back-to-back throughput is 1 op per 2 cycles for base ops.
- M special cases (1-cycle, skip BUSY):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give in1.
  - Signed overflow (in1 = 100..0, in2 = all ones): DIV gives in1, REM gives 0.
- kill:
  - In any state, next state is IDLE and out_valid drops. The result is discarded.
  - kill has priority over accept and out_ready in the same cycle.
- Reset:
  - rst_n low asynchronously forces IDLE, out_valid=0, alu_out=0, counter=0, latched operands=0.
  - in_ready=1 once reset is released.
  - Reset during BUSY or DONE abandons the operation with no output.
- Inputs are ignored outside IDLE. in1/in2/alu_op may change freely after the accept edge.

Test Plan:
- Base ops: ADD 0x7FFFFFFF+1 -> 0x80000000; SUB 0-1 -> 0xFFFFFFFF; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; SRA 0x80000000>>4 -> 0xF8000000. Each has out_valid exactly 1 cycle after accept.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF -> 1; MULHU same -> 0xFFFFFFFE; MULH same -> 0; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF. out_valid 33 cycles after accept, in_ready low throughout.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2. Latency 33 cycles.
- Corner divides: DIV x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0. Each has 1-cycle latency.
- Backpressure/kill: hold out_ready=0 for 10 cycles -> alu_out stable, in_ready=0. kill asserted at BUSY step 5 -> IDLE next cycle, no out_valid. kill together with out_ready in DONE -> IDLE, no double handshake.
- Reset: assert rst_n low mid-BUSY (no clock edge) -> out_valid=0 and in_ready=1 immediately after release; then ADD 2+3 -> 5 completes normally. Rerun suite at XLEN=16.
